// File: rtl/mmio_io_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_ctrl_pkg : shared widths, IO map and FSM encoding for mmio_io_ctrl |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mmio_io_ctrl_pkg;

  localparam int ISA_WIDTH = 32;
  localparam int IO_WIDTH  = 16;

  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

  localparam logic [9:0] LED_OFS  = 10'h060;
  localparam logic [9:0] SW_OFS   = 10'h070;
  localparam logic [9:0] SEG_OFS  = 10'h080;
  localparam logic [9:0] STAT_OFS = 10'h090;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_LED  = 3'd1,
    SEL_SW   = 3'd2,
    SEL_SEG  = 3'd3,
    SEL_STAT = 3'd4
  } io_sel_e;

  // Anything outside the top 1 KiB window, or at an unmapped offset, selects nothing.
  function automatic io_sel_e io_decode(input logic [ISA_WIDTH-1:0] addr);
    io_sel_e sel;
    sel = SEL_NONE;
    if (addr[31:10] == IO_BASE_HI) begin
      case (addr[9:0])
        LED_OFS:  sel = SEL_LED;
        SW_OFS:   sel = SEL_SW;
        SEG_OFS:  sel = SEL_SEG;
        STAT_OFS: sel = SEL_STAT;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_io_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_ctrl_if : CPU-side IO access bus (request, stall and read data)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mmio_io_ctrl_if;
  import mmio_io_ctrl_pkg::*;

  logic                 io_rd;
  logic                 io_wr;
  logic [ISA_WIDTH-1:0] addr;
  logic [ISA_WIDTH-1:0] wdata;
  logic                 stall;
  logic [ISA_WIDTH-1:0] io_rdata;

  modport master (
    output io_rd, io_wr, addr, wdata,
    input  stall, io_rdata
  );

  modport slave (
    input  io_rd, io_wr, addr, wdata,
    output stall, io_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mmio_io_ctrl_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_ctrl_sync_edge : multi-flop synchronizer plus rising-edge pulse    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mmio_io_ctrl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clock,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], d};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign pulse = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_io_ctrl : memory-mapped IO controller (LED/SEG regs, stalling switch  |
// |                read gated by the confirm button, sticky read timeout)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                 clock,
  input  wire logic                 rst_n,
  mmio_io_ctrl_if.slave             bus,
  input  wire logic [IO_WIDTH-1:0]  switches,
  input  wire logic                 confirm_button,
  output logic      [IO_WIDTH-1:0]  ledout,
  output logic      [ISA_WIDTH-1:0] seg_data,
  output logic                      rd_timeout
);

  io_state_e            r_state;
  io_state_e            w_next;
  logic [ISA_WIDTH-1:0] r_rdata;
  logic [IO_WIDTH-1:0]  r_led;
  logic [ISA_WIDTH-1:0] r_seg;
  logic                 r_to;

  io_sel_e              w_sel;
  logic                 w_rd;
  logic                 w_sw_req;
  logic                 w_pulse;
  logic                 w_timeout;
  logic                 w_stall;
  logic                 w_capture;
  logic [ISA_WIDTH-1:0] w_cap_val;
  logic                 w_set_to;
  logic [ISA_WIDTH-1:0] w_rdata;

  // A simultaneous write wins, so the read side only sees io_rd without io_wr.
  assign w_sel    = io_decode(bus.addr);
  assign w_rd     = bus.io_rd & ~bus.io_wr;
  assign w_sw_req = w_rd & (w_sel == SEL_SW);

  mmio_io_ctrl_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock (clock),
    .rst_n (rst_n),
    .d     (confirm_button),
    .pulse (w_pulse)
  );

  generate
    if (TIMEOUT_CYC != 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
      logic [CNT_W-1:0] r_cnt;

      // Held at zero outside WAIT so every new wait starts a fresh count; saturates.
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (r_state != WAIT) begin
          r_cnt <= '0;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_timeout = (r_cnt == CNT_LAST);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_capture = 1'b0;
    w_cap_val = '0;
    w_set_to  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sw_req) begin
          w_stall = 1'b1;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (!bus.io_rd) begin
          w_next = IDLE;
        end else if (w_pulse) begin
          w_capture = 1'b1;
          w_cap_val = {{(ISA_WIDTH-IO_WIDTH){1'b0}}, switches};
          w_next    = DONE;
        end else if (w_timeout) begin
          w_capture = 1'b1;
          w_set_to  = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_led   <= '0;
      r_seg   <= '0;
      r_to    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_rdata <= w_cap_val;
      end
      if (bus.io_wr && (w_sel == SEL_LED)) begin
        r_led <= bus.wdata[IO_WIDTH-1:0];
      end
      if (bus.io_wr && (w_sel == SEL_SEG)) begin
        r_seg <= bus.wdata;
      end
      if (w_set_to) begin
        r_to <= 1'b1;
      end else if (w_rd && (w_sel == SEL_STAT)) begin
        r_to <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_state == DONE) begin
      w_rdata = r_rdata;
    end else if (w_rd) begin
      case (w_sel)
        SEL_LED:  w_rdata = {{(ISA_WIDTH-IO_WIDTH){1'b0}}, r_led};
        SEL_SEG:  w_rdata = r_seg;
        SEL_STAT: w_rdata = {{(ISA_WIDTH-1){1'b0}}, r_to};
        default:  w_rdata = '0;
      endcase
    end
  end

  // Gating with rst_n keeps stall low while reset is held even if a switch read is still presented.
  assign bus.stall    = rst_n & w_stall;
  assign bus.io_rdata = w_rdata;
  assign ledout       = r_led;
  assign seg_data     = r_seg;
  assign rd_timeout   = r_to;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmio_io_ctrl : directed self-checking bench for mmio_io_ctrl            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mmio_io_ctrl;

  logic        clock;
  logic        rst_n;
  logic [15:0] switches;
  logic        confirm_button;
  logic [15:0] ledout;
  logic [31:0] seg_data;
  logic        rd_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(
    .TIMEOUT_CYC (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .bus            (bus),
    .switches       (switches),
    .confirm_button (confirm_button),
    .ledout         (ledout),
    .seg_data       (seg_data),
    .rd_timeout     (rd_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  // Drive at the falling edge, then let combinational outputs settle.
  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  task automatic bus_idle();
    bus.io_rd = 1'b0;
    bus.io_wr = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  // Wait for stall to drop; returns stalled samples seen.
  task automatic wait_release(input string tag, input int limit, output int cnt);
    cnt = 0;
    while (bus.stall && cnt < limit) begin
      cnt++;
      nxt();
    end
    if (bus.stall) chk({tag, "_bound"}, 32'(bus.stall), 32'h0);
  endtask

  initial begin
    int cnt;
    bit stall_ok;
    rst_n          = 1'b0;
    switches       = 16'h0;
    confirm_button = 1'b0;
    bus_idle();
    repeat (3) nxt();
    rst_n = 1'b1;
    nxt();

    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_rdata", bus.io_rdata, 32'h0);
    chk("rst_led",   32'(ledout), 32'h0);
    chk("rst_seg",   seg_data, 32'h0);
    chk("rst_to",    32'(rd_timeout), 32'h0);

    // LED write, read-back
    bus.io_wr = 1'b1; bus.addr = 32'hFFFF_FC60; bus.wdata = 32'h1234_ABCD;
    #1 chk("led_wr_stall", 32'(bus.stall), 32'h0);
    nxt();
    bus_idle();
    #1 chk("led_val", 32'(ledout), 32'h0000_ABCD);
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC60;
    #1 chk("led_rd", bus.io_rdata, 32'h0000_ABCD);
    chk("led_rd_stall", 32'(bus.stall), 32'h0);
    nxt();

    // SEG write, read-back
    bus_idle();
    bus.io_wr = 1'b1; bus.addr = 32'hFFFF_FC80; bus.wdata = 32'h1234_ABCD;
    nxt();
    bus_idle();
    #1 chk("seg_val", seg_data, 32'h1234_ABCD);
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC80;
    #1 chk("seg_rd", bus.io_rdata, 32'h1234_ABCD);
    nxt();

    // Switch read with press 10 cycles later
    bus_idle();
    switches = 16'h00A5;
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC70;
    #1 chk("sw_stall0", 32'(bus.stall), 32'h1);
    stall_ok = 1'b1;
    repeat (10) begin
      nxt();
      if (!bus.stall) stall_ok = 1'b0;
    end
    chk("sw_stall_held", 32'(stall_ok), 32'h1);
    confirm_button = 1'b1;
    nxt();
    wait_release("sw_rel", 8, cnt);
    chk("sw_data", bus.io_rdata, 32'h0000_00A5);
    chk("sw_done_stall", 32'(bus.stall), 32'h0);
    bus.io_rd = 1'b0;
    nxt();
    chk("sw_idle_rdata", bus.io_rdata, 32'h0);
    chk("sw_idle_stall", 32'(bus.stall), 32'h0);
    confirm_button = 1'b0;
    repeat (4) nxt();

    // Stale press in IDLE must not satisfy a later read
    confirm_button = 1'b1;
    repeat (3) nxt();
    confirm_button = 1'b0;
    repeat (4) nxt();
    switches = 16'h1234;
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC70;
    stall_ok = 1'b1;
    repeat (6) begin
      nxt();
      if (!bus.stall) stall_ok = 1'b0;
    end
    chk("stale_stall", 32'(stall_ok), 32'h1);
    confirm_button = 1'b1;
    nxt();
    wait_release("stale_rel", 8, cnt);
    chk("stale_data", bus.io_rdata, 32'h0000_1234);
    nxt();
    chk("b2b_stall", 32'(bus.stall), 32'h1);
    nxt();
    bus.io_rd = 1'b0;
    nxt();
    chk("abort_stall", 32'(bus.stall), 32'h0);
    chk("abort_rdata", bus.io_rdata, 32'h0);
    chk("abort_to", 32'(rd_timeout), 32'h0);
    confirm_button = 1'b0;
    repeat (4) nxt();

    // Timeout: one IDLE stall cycle plus 16 WAIT cycles
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC70;
    #1;
    wait_release("to_rel", 40, cnt);
    chk("to_cycles", 32'(cnt), 32'd17);
    chk("to_rdata", bus.io_rdata, 32'h0);
    chk("to_flag", 32'(rd_timeout), 32'h1);
    bus.io_rd = 1'b0;
    nxt();
    chk("to_sticky", 32'(rd_timeout), 32'h1);
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC90;
    #1 chk("stat_rd", bus.io_rdata, 32'h1);
    nxt();
    bus_idle();
    #1 chk("stat_clr", 32'(rd_timeout), 32'h0);

    // Read and write together on LED
    bus.io_rd = 1'b1; bus.io_wr = 1'b1; bus.addr = 32'hFFFF_FC60; bus.wdata = 32'h0000_5A5A;
    #1 chk("rw_rdata", bus.io_rdata, 32'h0);
    chk("rw_stall", 32'(bus.stall), 32'h0);
    nxt();
    bus_idle();
    #1 chk("rw_led", 32'(ledout), 32'h0000_5A5A);

    // Unmapped offset and out-of-window address
    bus.io_rd = 1'b1; bus.addr = 32'hFFFF_FC40;
    #1 chk("unmap_rdata", bus.io_rdata, 32'h0);
    chk("unmap_stall", 32'(bus.stall), 32'h0);
    bus.addr = 32'hFFFF_0070;
    #1 chk("nowin_stall", 32'(bus.stall), 32'h0);
    nxt();

    // Reset in WAIT drops stall at once and clears registers
    bus.addr = 32'hFFFF_FC70;
    nxt();
    chk("rstw_pre", 32'(bus.stall), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("rstw_stall", 32'(bus.stall), 32'h0);
    chk("rstw_led", 32'(ledout), 32'h0);
    chk("rstw_seg", seg_data, 32'h0);
    bus_idle();
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("rstw_after", 32'(bus.stall), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
